power_sequencer: RTL and testbench

Power-on/off sequencer for the RF power supply controller. It drives the anode supply enable, the G2 supply activate and the driver amplifier enable in a fixed order. Each stage waits for the matching permission/OK status from the interlock card before the next stage starts, and the block faults on alarm or timeout. It is the initiator side of the interlock-card interface: its enables feed the card's supply inputs, and the card's Not_* outputs come back as its inputs.

---
 rtl/pwrseq_pkg.sv | 42 ++++
 rtl/seq_timer.sv | 35 +++
 rtl/power_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_power_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwrseq_pkg.sv
// Shared types and widths for the RF power-supply sequencer.
// Included by power_sequencer and its stage timer.
package pwrseq_pkg;

  localparam int STATE_W = 3;
  localparam int PHASE_W = 2;
  localparam int CODE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_AN_RAMP  = 3'd1,
    ST_G2_RAMP  = 3'd2,
    ST_DR_RAMP  = 3'd3,
    ST_RUN      = 3'd4,
    ST_SHUTDOWN = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  typedef enum logic [PHASE_W-1:0] {
    SD_DR = 2'd0,
    SD_G2 = 2'd1,
    SD_AN = 2'd2
  } sd_phase_t;

  typedef enum logic [CODE_W-1:0] {
    FC_NONE     = 3'd0,
    FC_ALARM    = 3'd1,
    FC_AN_TO    = 3'd2,
    FC_G2_TO    = 3'd3,
    FC_DR_TO    = 3'd4,
    FC_RUN_LOST = 3'd5
  } fault_code_t;

  typedef struct packed {
    logic an;
    logic g2;
    logic dr;
    logic ready;
    logic fault;
  } out_t;

endpackage

// File: rtl/seq_timer.sv
// Saturating stage counter with synchronous clear; hit_o flags the last
// cycle of a stage (count == limit_i - 1).
module seq_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/power_sequencer.sv
// Anode / G2 / driver power-up and power-down sequencer facing the interlock card.
// Define PWRSEQ_FAULT_LOG_EN to latch the cause of each FAULT entry on o_fault_code.
module power_sequencer
  import pwrseq_pkg::*;
#(
  parameter int T_AN_TIMEOUT = 64,
  parameter int T_G2_TIMEOUT = 256,
  parameter int T_DR_TIMEOUT = 64,
  parameter int T_OFF_DWELL  = 16,
  parameter int CNT_W        = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_request,
  input  logic       off_request,
  input  logic       fault_clear,
  input  logic       i_not_alarm,
  input  logic       i_not_alarm2,
  input  logic       i_not_on_perm,
  input  logic       i_not_g2_ok,
  input  logic       i_not_u_g2_low,
  input  logic       i_not_dr_amp_ok,
  output logic       o_an_ps_en,
  output logic       o_g2_ps_act,
  output logic       o_dr_amp_en,
  output logic       o_ready,
  output logic       o_fault,
  output logic [2:0] o_state,
  output logic [2:0] o_fault_code
);

  localparam logic [CNT_W-1:0] AN_LIM    = CNT_W'(T_AN_TIMEOUT);
  localparam logic [CNT_W-1:0] G2_LIM    = CNT_W'(T_G2_TIMEOUT);
  localparam logic [CNT_W-1:0] DR_LIM    = CNT_W'(T_DR_TIMEOUT);
  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(T_OFF_DWELL);

  state_t           state_q, state_d;
  sd_phase_t        phase_q, phase_d;
  out_t             out_q, out_d;
  logic             alarm_ok, status_ok;
  logic             timer_clr, timer_en, timer_hit;
  logic [CNT_W-1:0] limit;

  assign alarm_ok  = i_not_alarm & i_not_alarm2;
  assign status_ok = ~(i_not_on_perm | i_not_g2_ok | i_not_u_g2_low | i_not_dr_amp_ok);

  always_comb begin
    limit = DWELL_LIM;
    case (state_q)
      ST_AN_RAMP: limit = AN_LIM;
      ST_G2_RAMP: limit = G2_LIM;
      ST_DR_RAMP: limit = DR_LIM;
      default:    limit = DWELL_LIM;
    endcase
  end

  // Every state or phase change restarts the stage count.
  assign timer_clr = (state_d != state_q) || (phase_d != phase_q);
  assign timer_en  = (state_q == ST_AN_RAMP) || (state_q == ST_G2_RAMP) ||
                     (state_q == ST_DR_RAMP) || (state_q == ST_SHUTDOWN);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (timer_clr),
    .en_i    (timer_en),
    .limit_i (limit),
    .hit_o   (timer_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= SD_DR;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Priority in active states: alarm, then off_request, then advance, then timeout.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (on_request && !off_request && alarm_ok) state_d = ST_AN_RAMP;
      end
      ST_AN_RAMP: begin
        if (!alarm_ok)          state_d = ST_FAULT;
        else if (off_request)   begin state_d = ST_SHUTDOWN; phase_d = SD_AN; end
        else if (!i_not_on_perm) state_d = ST_G2_RAMP;
        else if (timer_hit)     state_d = ST_FAULT;
      end
      ST_G2_RAMP: begin
        if (!alarm_ok)        state_d = ST_FAULT;
        else if (off_request) begin state_d = ST_SHUTDOWN; phase_d = SD_G2; end
        else if (!i_not_g2_ok && !i_not_u_g2_low) state_d = ST_DR_RAMP;
        else if (timer_hit)   state_d = ST_FAULT;
      end
      ST_DR_RAMP: begin
        if (!alarm_ok)            state_d = ST_FAULT;
        else if (off_request)     begin state_d = ST_SHUTDOWN; phase_d = SD_DR; end
        else if (!i_not_dr_amp_ok) state_d = ST_RUN;
        else if (timer_hit)       state_d = ST_FAULT;
      end
      ST_RUN: begin
        if (!alarm_ok)        state_d = ST_FAULT;
        else if (off_request) begin state_d = ST_SHUTDOWN; phase_d = SD_DR; end
        else if (!status_ok)  state_d = ST_FAULT;
      end
      ST_SHUTDOWN: begin
        if (!alarm_ok) begin
          state_d = ST_FAULT;
        end else if (timer_hit) begin
          case (phase_q)
            SD_DR:   phase_d = SD_G2;
            SD_G2:   phase_d = SD_AN;
            default: begin state_d = ST_IDLE; phase_d = SD_DR; end
          endcase
        end
      end
      ST_FAULT: begin
        if (fault_clear && !on_request && alarm_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so they register on the same edge as the state.
  always_comb begin
    out_d = '0;
    case (state_d)
      ST_AN_RAMP:  out_d.an = 1'b1;
      ST_G2_RAMP:  begin out_d.an = 1'b1; out_d.g2 = 1'b1; end
      ST_DR_RAMP:  begin out_d.an = 1'b1; out_d.g2 = 1'b1; out_d.dr = 1'b1; end
      ST_RUN:      begin
        out_d.an    = 1'b1;
        out_d.g2    = 1'b1;
        out_d.dr    = 1'b1;
        out_d.ready = 1'b1;
      end
      ST_SHUTDOWN: begin
        out_d.an = (phase_d != SD_AN);
        out_d.g2 = (phase_d == SD_DR);
      end
      ST_FAULT:    out_d.fault = 1'b1;
      default:     out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign o_an_ps_en  = out_q.an;
  assign o_g2_ps_act = out_q.g2;
  assign o_dr_amp_en = out_q.dr;
  assign o_ready     = out_q.ready;
  assign o_fault     = out_q.fault;
  assign o_state     = state_q;

`ifdef PWRSEQ_FAULT_LOG_EN
  fault_code_t cause, code_q;

  // Only meaningful on the cycle FAULT is entered; shutdown can only fault on alarm.
  always_comb begin
    cause = FC_ALARM;
    if (alarm_ok) begin
      case (state_q)
        ST_AN_RAMP: cause = FC_AN_TO;
        ST_G2_RAMP: cause = FC_G2_TO;
        ST_DR_RAMP: cause = FC_DR_TO;
        ST_RUN:     cause = FC_RUN_LOST;
        default:    cause = FC_ALARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= FC_NONE;
    end else if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
      code_q <= cause;
    end
  end

  assign o_fault_code = code_q;
`else
  assign o_fault_code = 3'd0;
`endif

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer: a vector table for the short sequences and
// hand-written loops for the timeout, dwell and asynchronous-reset corners.
module tb_power_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       on_request, off_request, fault_clear;
  logic       i_not_alarm, i_not_alarm2, i_not_on_perm;
  logic       i_not_g2_ok, i_not_u_g2_low, i_not_dr_amp_ok;
  logic       o_an_ps_en, o_g2_ps_act, o_dr_amp_en, o_ready, o_fault;
  logic [2:0] o_state, o_fault_code;

  int n_checks = 0;
  int n_pass   = 0;

  // inputs packed as {on, off, clr, alarm, alarm2, on_perm, g2_ok, u_g2_low, dr_amp_ok}
  typedef struct {
    logic [8:0] in;
    logic [2:0] st;
    logic [4:0] en;   // {an, g2, dr, ready, fault}
    logic [2:0] code;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  power_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .on_request      (on_request),
    .off_request     (off_request),
    .fault_clear     (fault_clear),
    .i_not_alarm     (i_not_alarm),
    .i_not_alarm2    (i_not_alarm2),
    .i_not_on_perm   (i_not_on_perm),
    .i_not_g2_ok     (i_not_g2_ok),
    .i_not_u_g2_low  (i_not_u_g2_low),
    .i_not_dr_amp_ok (i_not_dr_amp_ok),
    .o_an_ps_en      (o_an_ps_en),
    .o_g2_ps_act     (o_g2_ps_act),
    .o_dr_amp_en     (o_dr_amp_en),
    .o_ready         (o_ready),
    .o_fault         (o_fault),
    .o_state         (o_state),
    .o_fault_code    (o_fault_code)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ec(input logic [2:0] c);
`ifdef PWRSEQ_FAULT_LOG_EN
    return c;
`else
    return 3'd0;
`endif
  endfunction

  function automatic logic [4:0] outs();
    return {o_an_ps_en, o_g2_ps_act, o_dr_amp_en, o_ready, o_fault};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic check_all(input string name, input logic [2:0] st,
                           input logic [4:0] en, input logic [2:0] code);
    check({name, ".state"}, {6'd0, o_state}, {6'd0, st});
    check({name, ".enables"}, {4'd0, outs()}, {4'd0, en});
    check({name, ".code"}, {6'd0, o_fault_code}, {6'd0, ec(code)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] v);
    {on_request, off_request, fault_clear, i_not_alarm, i_not_alarm2,
     i_not_on_perm, i_not_g2_ok, i_not_u_g2_low, i_not_dr_amp_ok} = v;
  endtask

  localparam logic [8:0] BASE = 9'b000_11_0000;

  initial begin
    int held;
    vecs[0]  = '{9'b110_11_0000, 3'd0, 5'b00000, 3'd0};
    vecs[1]  = '{9'b100_01_0000, 3'd0, 5'b00000, 3'd0};
    vecs[2]  = '{9'b100_11_0000, 3'd1, 5'b10000, 3'd0};
    vecs[3]  = '{9'b000_11_0000, 3'd2, 5'b11000, 3'd0};
    vecs[4]  = '{9'b000_11_0000, 3'd3, 5'b11100, 3'd0};
    vecs[5]  = '{9'b000_11_0000, 3'd4, 5'b11110, 3'd0};
    vecs[6]  = '{9'b100_11_0000, 3'd4, 5'b11110, 3'd0};
    vecs[7]  = '{9'b000_10_0000, 3'd6, 5'b00001, 3'd1};
    vecs[8]  = '{9'b101_11_0000, 3'd6, 5'b00001, 3'd1};
    vecs[9]  = '{9'b001_01_0000, 3'd6, 5'b00001, 3'd1};
    vecs[10] = '{9'b001_11_0000, 3'd0, 5'b00000, 3'd1};
    vecs[11] = '{9'b100_11_0000, 3'd1, 5'b10000, 3'd1};
    vecs[12] = '{9'b000_11_1000, 3'd1, 5'b10000, 3'd1};
    vecs[13] = '{9'b010_11_1000, 3'd5, 5'b00000, 3'd1};
    vecs[14] = '{9'b100_11_1000, 3'd5, 5'b00000, 3'd1};

    // Clock/reset
    reset = 1'b0;
    drive(BASE);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 5'b00000, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_all("post_reset_idle", 3'd0, 5'b00000, 3'd0);

    // Table: bring-up, alarm fault, clear rules, off from AN_RAMP
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].in);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].code);
    end

    // Remaining dwell in SD_AN: IDLE exactly 16 edges after SHUTDOWN entry
    drive(BASE);
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 14) check_all("sd_an_dwell_end", 3'd5, 5'b00000, 3'd1);
      if (k == 15) check_all("sd_an_to_idle", 3'd0, 5'b00000, 3'd1);
    end

    // RUN_LOST
    drive(9'b100_11_0000); step();
    drive(BASE); step(); step(); step();
    check_all("run_reached", 3'd4, 5'b11110, 3'd1);
    drive(9'b000_11_0001); step();
    check_all("run_lost", 3'd6, 5'b00001, 3'd5);
    drive(9'b001_11_0000); step();
    check_all("run_lost_clear", 3'd0, 5'b00000, 3'd5);

    // G2 held off for 255 cycles, then released in the last allowed cycle
    drive(9'b100_11_0100); step();
    drive(9'b000_11_0100); step();
    check_all("g2_entry", 3'd2, 5'b11000, 3'd5);
    held = 0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (o_state == 3'd2) held++;
    end
    check("g2_hold_cycles", 9'(held), 9'd255);
    drive(BASE); step();
    check_all("g2_late_ok", 3'd3, 5'b11100, 3'd5);
    step();
    check_all("run_after_late_g2", 3'd4, 5'b11110, 3'd5);

    // Shutdown from RUN: dr at t, g2 at t+16, an at t+32, IDLE at t+48
    drive(9'b010_11_0000); step();
    check_all("sd_t0", 3'd5, 5'b11000, 3'd5);
    drive(9'b100_11_0000);
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k == 15) check_all("sd_t15", 3'd5, 5'b11000, 3'd5);
      if (k == 16) check_all("sd_t16", 3'd5, 5'b10000, 3'd5);
      if (k == 31) check_all("sd_t31", 3'd5, 5'b10000, 3'd5);
      if (k == 32) check_all("sd_t32", 3'd5, 5'b00000, 3'd5);
      if (k == 47) check_all("sd_t47", 3'd5, 5'b00000, 3'd5);
      if (k == 48) check_all("sd_t48", 3'd0, 5'b00000, 3'd5);
    end

    // G2 timeout at entry +256
    drive(BASE); step();
    drive(9'b100_11_0100); step();
    drive(9'b000_11_0100); step();
    held = 0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (o_state == 3'd2) held++;
    end
    check("g2_to_wait", 9'(held), 9'd255);
    step();
    check_all("g2_timeout", 3'd6, 5'b00001, 3'd3);
    drive(9'b001_11_0000); step();
    check_all("g2_to_clear", 3'd0, 5'b00000, 3'd3);

    // AN timeout at entry +64
    drive(9'b100_11_1000); step();
    drive(9'b000_11_1000);
    held = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (o_state == 3'd1) held++;
    end
    check("an_to_wait", 9'(held), 9'd63);
    step();
    check_all("an_timeout", 3'd6, 5'b00001, 3'd2);
    drive(9'b001_11_0000); step();
    check_all("an_to_clear", 3'd0, 5'b00000, 3'd2);

    // Asynchronous reset in DR_RAMP
    drive(9'b100_11_0001); step();
    drive(9'b000_11_0001); step(); step();
    check_all("dr_ramp_hold", 3'd3, 5'b11100, 3'd2);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 3'd0, 5'b00000, 3'd0);
    drive(BASE);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_all("after_async_reset", 3'd0, 5'b00000, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
